// File: rtl/aes_inv_cipher.sv
// AES-128 iterative inverse cipher: one round per clock. Round keys are produced on the fly
// by expanding forward to round key 10, then stepping the schedule backwards each round.

module aes_inv_shift_rows (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    // Row r of column c takes the byte that sat in column (c - r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign state_o[8*(15-(4*c+r)) +: 8] = state_i[8*(15-(4*((c+4-r)%4)+r)) +: 8];
        end
    end
endmodule

module aes_inv_cipher (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] cyphertext,
    output logic [127:0] plaintext,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL, DONE} fsm_e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    fsm_e         fsm_q;
    logic [127:0] state_q, key_q, pt_q;
    logic [7:0]   rcon_q;
    logic [3:0]   cnt_q;
    logic         done_q;

    logic [127:0] isr_d, ark_d, round_d, key_fwd_d, key_back_d;

    // Entry 0 sits in the top byte of each table, hence the inverted index.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return (b == 8'h1b) ? 8'h80 : {1'b0, b[7:1]};
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = inv_mix_col(s[32*i +: 32]);
        return r;
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expansion step: recover the old w3 first, since w0 depends on it.
    function automatic logic [127:0] key_back(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    aes_inv_shift_rows u_isr (
        .state_i(state_q),
        .state_o(isr_d)
    );

    always_comb begin
        ark_d      = inv_sub_bytes(isr_d) ^ key_q;
        round_d    = inv_mix_columns(ark_d);
        key_fwd_d  = key_fwd(key_q, rcon_q);
        key_back_d = key_back(key_q, rcon_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            rcon_q  <= 8'h01;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (load) begin
                        key_q   <= key;
                        state_q <= cyphertext;
                        done_q  <= 1'b0;
                        rcon_q  <= 8'h01;
                        cnt_q   <= '0;
                        fsm_q   <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    key_q <= key_fwd_d;
                    // rcon stays on 0x36 after the last step: it is the first value the backward walk needs.
                    if (cnt_q == 4'd9) begin
                        fsm_q <= ADDKEY;
                    end else begin
                        rcon_q <= xtime(rcon_q);
                        cnt_q  <= cnt_q + 4'd1;
                    end
                end
                ADDKEY: begin
                    state_q <= state_q ^ key_q;
                    key_q   <= key_back_d;
                    rcon_q  <= inv_xtime(rcon_q);
                    cnt_q   <= 4'd9;
                    fsm_q   <= ROUND;
                end
                ROUND: begin
                    state_q <= round_d;
                    key_q   <= key_back_d;
                    rcon_q  <= inv_xtime(rcon_q);
                    cnt_q   <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) fsm_q <= FINAL;
                end
                FINAL: begin
                    state_q <= ark_d;
                    pt_q    <= ark_d;
                    done_q  <= 1'b1;
                    fsm_q   <= DONE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign plaintext = pt_q;
    assign done      = done_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed + randomized bench for aes_inv_cipher against a byte-level AES-128 decryption model
// whose S-boxes are derived from GF(2^8) inversion plus the affine map.

module tb_aes_inv_cipher;
    logic         clk = 1'b0;
    logic         reset, load;
    logic [127:0] key, cyphertext, plaintext;
    logic         done;
    logic [127:0] isr_in, isr_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];
    localparam logic [7:0] MIX [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_inv_cipher dut (
        .clk(clk), .reset(reset), .load(load), .key(key),
        .cyphertext(cyphertext), .plaintext(plaintext), .done(done)
    );

    aes_inv_shift_rows u_isr (.state_i(isr_in), .state_o(isr_out));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic void build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endfunction

    // Byte i of the block is row i%4, column i/4.
    function automatic logic [127:0] model_isr(input logic [127:0] in);
        logic [127:0] out;
        out = '0;
        for (int i = 0; i < 16; i++)
            out[127-8*i -: 8] = in[127-8*((i%4) + 4*(((i/4) - (i%4) + 4) % 4)) -: 8];
        return out;
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] c);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)];
            for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ w[4*r + i/4][31-8*(i%4) -: 8];
            if (r > 0) begin
                for (int col = 0; col < 4; col++)
                    for (int i = 0; i < 4; i++) begin
                        t[4*col+i] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            t[4*col+i] ^= gmul(MIX[(j - i + 4) % 4], s[4*col+j]);
                    end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Launches one operation and returns the cycle count until done rises (0 if it never does).
    task automatic run_op(input logic [127:0] k, input logic [127:0] c, input bit mid_load,
                          input bit scramble, output int lat);
        load = 1'b1;
        key = k;
        cyphertext = c;
        tick();
        load = 1'b0;
        check("load_clears_done", 128'(done), 128'(0));
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            load = mid_load && (i == 5);
            if (scramble || load) begin
                key = rand128();
                cyphertext = rand128();
            end
            tick();
            if (done === 1'b1) lat = i;
        end
        load = 1'b0;
    endtask

    initial begin
        logic [127:0] k, c, exp_pt, v;
        int lat;
        bit stable, saw_done;

        reset = 1'b1;
        load = 1'b0;
        key = '0;
        cyphertext = '0;
        isr_in = '0;
        build_tables();
        repeat (3) tick();
        check("reset_done", 128'(done), 128'(0));
        check("reset_pt", plaintext, 128'(0));
        reset = 1'b0;
        tick();
        check("idle_done", 128'(done), 128'(0));

        run_op(K1, C1, 1'b0, 1'b0, lat);
        check("fips_b_latency", 128'(lat), 128'(21));
        check("fips_b_pt", plaintext, P1);

        stable = 1'b1;
        repeat (50) begin
            tick();
            if (done !== 1'b1 || plaintext !== P1) stable = 1'b0;
        end
        check("done_hold_50", 128'(stable), 128'(1));

        run_op(K2, C2, 1'b0, 1'b0, lat);
        check("fips_c1_latency", 128'(lat), 128'(21));
        check("fips_c1_pt", plaintext, P2);

        run_op(K1, C1, 1'b1, 1'b0, lat);
        check("midload_latency", 128'(lat), 128'(21));
        check("midload_pt", plaintext, P1);

        for (int n = 0; n < 5; n++) begin
            k = rand128();
            c = rand128();
            exp_pt = model_decrypt(k, c);
            run_op(k, c, n == 4, 1'b1, lat);
            check("rand_latency", 128'(lat), 128'(21));
            check("rand_pt", plaintext, exp_pt);
        end

        // Abort mid-run with an asynchronous reset, with load held high during reset.
        load = 1'b1;
        key = K2;
        cyphertext = C2;
        tick();
        load = 1'b0;
        repeat (11) tick();
        #3 reset = 1'b1;
        #1;
        check("abort_done", 128'(done), 128'(0));
        check("abort_pt", plaintext, 128'(0));
        load = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        load = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done !== 1'b0) saw_done = 1'b1;
        end
        check("abort_no_done", 128'(saw_done), 128'(0));
        check("abort_pt_stays", plaintext, 128'(0));

        k = rand128();
        c = rand128();
        exp_pt = model_decrypt(k, c);
        run_op(k, c, 1'b0, 1'b0, lat);
        check("post_abort_latency", 128'(lat), 128'(21));
        check("post_abort_pt", plaintext, exp_pt);

        isr_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        #1;
        check("isr_fixed", isr_out, 128'hd42711aee0bf98f1b8b45de51e415230);
        for (int n = 0; n < 4; n++) begin
            v = rand128();
            isr_in = v;
            #1;
            check("isr_rand", isr_out, model_isr(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
